// File: rtl/vram_arb_pkg.sv
// ---------------------------------------------------------------------------
// vram_arb_pkg
// Shared definitions for the VRAM arbiter: owner encodings for the single
// RAM port and the CPU replay state machine encodings.
// Optional feature macro used by the arbiter: VRAM_ARB_AGE_EN.
// ---------------------------------------------------------------------------
package vram_arb_pkg;

    // Which requester drove the RAM port in a given cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_CPU  = 2'd2,
        OWN_DMA  = 2'd3
    } owner_e;

    // CPU replay sequencer.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_REPLAY = 1'b1
    } state_e;

endpackage : vram_arb_pkg

// File: rtl/vram_arb_hold.sv
// ---------------------------------------------------------------------------
// vram_arb_hold
// Capture register for a CPU access that lost the RAM port. Holds the
// write enable, address and write data until the replay is issued.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   i_load            capture i_we/i_addr/i_din (wins over i_clear)
//   i_clear           drop the held write enable after the replay
//   i_we/i_addr/i_din access to capture
//   o_we/o_addr/o_din held access
// ---------------------------------------------------------------------------
module vram_arb_hold #(
    parameter int AW = 15,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_load,
    input  logic          i_clear,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_din,
    output logic          o_we,
    output logic [AW-1:0] o_addr,
    output logic [DW-1:0] o_din
);

    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_din;

    // NOTE: address/data are reset along with the enable; they are a handful
    // of flops, so a fully defined post-reset state costs nothing.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_we   <= 1'b0;
            r_addr <= '0;
            r_din  <= '0;
        end else if (i_load) begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge values, independent of statement order.
            r_we   <= i_we;
            r_addr <= i_addr;
            r_din  <= i_din;
        end else if (i_clear) begin
            r_we   <= 1'b0;
        end
    end

    assign o_we   = r_we;
    assign o_addr = r_addr;
    assign o_din  = r_din;

endmodule : vram_arb_hold

// File: rtl/vram_arbiter.sv
// ---------------------------------------------------------------------------
// vram_arbiter
// Single-port VRAM arbiter. One owner per cycle, priority:
//   video fetch > CPU replay > live CPU > DMA.
// A CPU access that collides with a higher-priority owner is captured and
// replayed on the next free cycle while cpu_rdy is held low.
// Optional feature (macro VRAM_ARB_AGE_EN): DMA age counter; after AGE_MAX
// consecutive losses to live CPU, DMA beats the CPU once.
// Ports:
//   clk, reset                        16 MHz clock, async active-high reset
//   vid_req/vid_addr                  video fetch strobe and address
//   cpu_sel/cpu_we/cpu_addr/cpu_din   CPU access; cpu_rdy = 0 stalls CPU
//   dma_req/dma_we/dma_addr/dma_din   DMA request; dma_gnt = issued now
//   dma_rvalid/dma_dout               DMA read data, one cycle after grant
//   cpu_dout                          CPU read data
//   mem_we/mem_addr/mem_din/mem_dout  RAM port
// ---------------------------------------------------------------------------
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int AW      = 15,
    parameter int DW      = 8,
    parameter int AGE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    input  logic          cpu_sel,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    output logic          cpu_rdy,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_din,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [DW-1:0] dma_dout,
    output logic [DW-1:0] cpu_dout,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    state_e        r_state;
    logic          r_cpu_rdy;
    logic          r_dma_rvalid;
    owner_e        r_rd_owner;

    owner_e        w_owner;
    logic          w_replay;
    logic          w_dma_promote;
    logic          w_collision;
    logic          w_replay_issue;
    logic          w_hold_we;
    logic [AW-1:0] w_hold_addr;
    logic [DW-1:0] w_hold_din;

    assign w_replay = (r_state == ST_REPLAY);

`ifdef VRAM_ARB_AGE_EN
    localparam int AGE_W = $clog2(AGE_MAX + 1);

    logic [AGE_W-1:0] r_age;
    logic             w_age_deny;

    assign w_dma_promote = dma_req && (r_age == AGE_W'(AGE_MAX));

    // DMA lost this cycle purely because a live CPU access was present.
    assign w_age_deny = dma_req && cpu_sel && !vid_req && !w_replay && !w_dma_promote;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_age <= '0;
        end else if (!dma_req || dma_gnt) begin
            r_age <= '0;
        end else if (w_age_deny) begin
            r_age <= r_age + 1'b1;
        end
    end
`else
    assign w_dma_promote = 1'b0;
`endif

    // Owner selection. Reset forces no owner so the RAM sees no write while
    // reset is asserted, whatever the requesters are doing.
    always_comb begin
        // NOTE: default first so every path assigns w_owner and no latch forms.
        w_owner = OWN_NONE;
        if (reset)              w_owner = OWN_NONE;
        else if (vid_req)       w_owner = OWN_VID;
        else if (w_replay)      w_owner = OWN_CPU;
        else if (w_dma_promote) w_owner = OWN_DMA;
        else if (cpu_sel)       w_owner = OWN_CPU;
        else if (dma_req)       w_owner = OWN_DMA;
    end

    // A live CPU access loses to video or to a promoted DMA; cpu_sel is
    // ignored while a replay is pending because the CPU is already stalled.
    assign w_collision    = !reset && cpu_sel && !w_replay && (vid_req || w_dma_promote);
    assign w_replay_issue = !reset && w_replay && !vid_req;

    vram_arb_hold #(
        .AW (AW),
        .DW (DW)
    ) u_hold (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_collision),
        .i_clear (w_replay_issue),
        .i_we    (cpu_we),
        .i_addr  (cpu_addr),
        .i_din   (cpu_din),
        .o_we    (w_hold_we),
        .o_addr  (w_hold_addr),
        .o_din   (w_hold_din)
    );

    // RAM port mux. Idle cycles park on the CPU address with writes off.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = cpu_addr;
        mem_din  = cpu_din;
        unique case (w_owner)
            OWN_VID: begin
                mem_addr = vid_addr;
            end
            OWN_CPU: begin
                if (w_replay) begin
                    mem_we   = w_hold_we;
                    mem_addr = w_hold_addr;
                    mem_din  = w_hold_din;
                end else begin
                    mem_we   = cpu_we;
                end
            end
            OWN_DMA: begin
                mem_we   = dma_we;
                mem_addr = dma_addr;
                mem_din  = dma_din;
            end
            default: ;
        endcase
    end

    assign dma_gnt = (w_owner == OWN_DMA);

    // Replay sequencer and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cpu_rdy    <= 1'b1;
            r_dma_rvalid <= 1'b0;
            r_rd_owner   <= OWN_NONE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_collision) begin
                        r_state   <= ST_REPLAY;
                        r_cpu_rdy <= 1'b0;
                    end else begin
                        r_cpu_rdy <= 1'b1;
                    end
                end
                ST_REPLAY: begin
                    if (vid_req) begin
                        r_cpu_rdy <= 1'b0;
                    end else begin
                        r_state   <= ST_IDLE;
                        r_cpu_rdy <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_cpu_rdy <= 1'b1;
                end
            endcase
            r_dma_rvalid <= dma_gnt && !dma_we;
            r_rd_owner   <= w_owner;
        end
    end

    assign cpu_rdy = r_cpu_rdy;
    // Read data belongs to DMA only when the previous cycle's owner was DMA.
    assign dma_rvalid = r_dma_rvalid && (r_rd_owner == OWN_DMA);
    assign dma_dout   = mem_dout;
    assign cpu_dout   = mem_dout;

endmodule : vram_arbiter

// File: tb/tb_vram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_vram_arbiter
// Directed bench for vram_arbiter. Inputs change 1 ns after the rising
// edge; outputs are compared on the falling edge (or 1 ns after an
// asynchronous reset edge).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vram_arbiter;

    localparam int AW = 15;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          cpu_sel;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_din;
    logic          cpu_rdy;
    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_din;
    logic          dma_gnt;
    logic          dma_rvalid;
    logic [DW-1:0] dma_dout;
    logic [DW-1:0] cpu_dout;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vram_arbiter #(
        .AW      (AW),
        .DW      (DW),
        .AGE_MAX (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .cpu_sel    (cpu_sel),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_din    (cpu_din),
        .cpu_rdy    (cpu_rdy),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_din    (dma_din),
        .dma_gnt    (dma_gnt),
        .dma_rvalid (dma_rvalid),
        .dma_dout   (dma_dout),
        .cpu_dout   (cpu_dout),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        vid_req  = 1'b0;
        vid_addr = '0;
        cpu_sel  = 1'b0;
        cpu_we   = 1'b0;
        cpu_addr = '0;
        cpu_din  = '0;
        dma_req  = 1'b0;
        dma_we   = 1'b0;
        dma_addr = '0;
        dma_din  = '0;
        mem_dout = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic exp_gnt;
        logic exp_rdy;
        logic [AW-1:0] exp_addr;
        int n_writes;
        int n_gnt;

        // ---- reset state, with a CPU write pending on the inputs ----
        idle_inputs();
        reset    = 1'b1;
        cpu_sel  = 1'b1;
        cpu_we   = 1'b1;
        cpu_addr = 15'h0011;
        #2;
        check("rst_cpu_rdy",    cpu_rdy,    1);
        check("rst_dma_rvalid", dma_rvalid, 0);
        check("rst_dma_gnt",    dma_gnt,    0);
        check("rst_mem_we",     mem_we,     0);
        tick();
        reset = 1'b0;
        idle_inputs();

        // ---- 1: plain CPU write ----
        tick();
        cpu_sel = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0123; cpu_din = 8'h5A;
        @(negedge clk);
        check("t1_mem_we",   mem_we,   1);
        check("t1_mem_addr", mem_addr, 15'h0123);
        check("t1_mem_din",  mem_din,  8'h5A);
        check("t1_cpu_rdy",  cpu_rdy,  1);
        tick();
        idle_inputs();
        @(negedge clk);
        check("t1_cpu_rdy_after", cpu_rdy, 1);
        check("t1_idle_we",       mem_we,  0);

        // ---- 2: CPU write collides with video ----
        tick();
        vid_req = 1'b1; vid_addr = 15'h0040;
        cpu_sel = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h1000; cpu_din = 8'hA5;
        @(negedge clk);
        check("t2_c0_addr", mem_addr, 15'h0040);
        check("t2_c0_we",   mem_we,   0);
        tick();
        vid_req = 1'b0;
        @(negedge clk);
        check("t2_c1_rdy",  cpu_rdy,  0);
        check("t2_c1_addr", mem_addr, 15'h1000);
        check("t2_c1_we",   mem_we,   1);
        check("t2_c1_din",  mem_din,  8'hA5);
        tick();
        idle_inputs();
        @(negedge clk);
        check("t2_c2_rdy", cpu_rdy, 1);
        check("t2_c2_we",  mem_we,  0);

        // ---- 3: DMA read on idle bus ----
        tick();
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 15'h0200;
        @(negedge clk);
        check("t3_gnt",    dma_gnt,    1);
        check("t3_addr",   mem_addr,   15'h0200);
        check("t3_we",     mem_we,     0);
        check("t3_rv_c0",  dma_rvalid, 0);
        tick();
        idle_inputs();
        mem_dout = 8'h3C;
        @(negedge clk);
        check("t3_rv_c1",  dma_rvalid, 1);
        check("t3_dout",   dma_dout,   8'h3C);
        check("t3_gnt_c1", dma_gnt,    0);
        tick();
        @(negedge clk);
        check("t3_rv_c2",  dma_rvalid, 0);

        // ---- DMA write: granted, written, no read-valid ----
        tick();
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 15'h0700; dma_din = 8'h11;
        @(negedge clk);
        check("dw_gnt",  dma_gnt,  1);
        check("dw_we",   mem_we,   1);
        check("dw_addr", mem_addr, 15'h0700);
        check("dw_din",  mem_din,  8'h11);
        tick();
        idle_inputs();
        @(negedge clk);
        check("dw_rv", dma_rvalid, 0);

        // ---- 4: DMA vs continuous CPU for 10 cycles ----
        n_gnt = 0;
        tick();
        cpu_sel = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0300;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 15'h0400; dma_din = 8'h77;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
`ifdef VRAM_ARB_AGE_EN
            exp_gnt  = (i == 4);
            exp_rdy  = (i != 5);
            exp_addr = (i == 4) ? 15'h0400 : 15'h0300;
`else
            exp_gnt  = 1'b0;
            exp_rdy  = 1'b1;
            exp_addr = 15'h0300;
`endif
            check($sformatf("t4_gnt_%0d", i),  dma_gnt,  exp_gnt);
            check($sformatf("t4_rdy_%0d", i),  cpu_rdy,  exp_rdy);
            check($sformatf("t4_addr_%0d", i), mem_addr, exp_addr);
            if (dma_gnt) n_gnt++;
            tick();
        end
`ifdef VRAM_ARB_AGE_EN
        check("t4_gnt_count", n_gnt, 1);
`else
        check("t4_gnt_count", n_gnt, 0);
`endif
        idle_inputs();

        // ---- 5: video on two consecutive cycles with CPU write ----
        n_writes = 0;
        tick();
        vid_req = 1'b1; vid_addr = 15'h0041;
        cpu_sel = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0555; cpu_din = 8'hC3;
        @(negedge clk);
        check("t5_c0_addr", mem_addr, 15'h0041);
        check("t5_c0_we",   mem_we,   0);
        check("t5_c0_rdy",  cpu_rdy,  1);
        tick();
        vid_addr = 15'h0042;
        @(negedge clk);
        check("t5_c1_rdy",  cpu_rdy,  0);
        check("t5_c1_addr", mem_addr, 15'h0042);
        check("t5_c1_we",   mem_we,   0);
        tick();
        vid_req = 1'b0;
        @(negedge clk);
        check("t5_c2_rdy",  cpu_rdy,  0);
        check("t5_c2_we",   mem_we,   1);
        check("t5_c2_addr", mem_addr, 15'h0555);
        check("t5_c2_din",  mem_din,  8'hC3);
        if (mem_we && mem_addr == 15'h0555) n_writes++;
        tick();
        idle_inputs();
        @(negedge clk);
        check("t5_c3_rdy", cpu_rdy, 1);
        check("t5_c3_we",  mem_we,  0);
        if (mem_we && mem_addr == 15'h0555) n_writes++;
        check("t5_write_count", n_writes, 1);

        // ---- 6: reset during a REPLAY cycle ----
        tick();
        vid_req = 1'b1; vid_addr = 15'h0043;
        cpu_sel = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0666; cpu_din = 8'h99;
        tick();
        vid_req = 1'b0;
        @(negedge clk);
        check("t6_pre_rdy", cpu_rdy, 0);
        check("t6_pre_we",  mem_we,  1);
        reset = 1'b1;
        #1;
        check("t6_rst_rdy", cpu_rdy, 1);
        check("t6_rst_we",  mem_we,  0);
        tick();
        idle_inputs();
        reset = 1'b0;
        n_writes = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("t6_post_rdy_%0d", i), cpu_rdy, 1);
            if (mem_we) n_writes++;
            tick();
        end
        check("t6_no_replay_write", n_writes, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_vram_arbiter
